// File: rtl/serial_frame_feeder_if.sv
// Handshake and serial-output bundle for serial_frame_feeder.
//   load  : request to accept din (master -> feeder)
//   din   : parallel word, WIDTH bits (master -> feeder)
//   ready : feeder idle, can accept a word (feeder -> master)
//   data  : serial bit toward the downstream chain (feeder -> master)
//   busy  : frame being shifted out (feeder -> master)
//   done  : one-cycle pulse once the whole word is in the chain (feeder -> master)
interface serial_frame_feeder_if #(
  parameter int unsigned WIDTH = 5
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             data;
  logic             busy;
  logic             done;

  modport master (
    output load,
    output din,
    input  ready,
    input  data,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  din,
    output ready,
    output data,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_frame_feeder.sv
// Parallel-to-serial front end for a WIDTH-stage serial-in shift chain.
// Accepts a word on load while ready, then drives it one bit per clock on data.
//   clk   : single clock, posedge
//   reset : asynchronous, active-high
//   bus   : serial_frame_feeder_if.slave (load/din in; ready/data/busy/done out)
// LSB_FIRST=0 sends din[WIDTH-1] first; LSB_FIRST=1 sends din[0] first.
module serial_frame_feeder #(
  parameter int unsigned WIDTH     = 5,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_frame_feeder_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CntW-1:0]  cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] din_ord;

  // The shifter always emits sr[WIDTH-1] first, so LSB-first frames are
  // reversed on the way in.
  always_comb begin
    din_ord = bus.din;
    if (LSB_FIRST) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        din_ord[i] = bus.din[WIDTH-1-i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load) begin
            sr_q    <= din_ord;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          // load is ignored here; the frame in flight is never disturbed.
          sr_q <= {sr_q[WIDTH-2:0], 1'b0};
          if (cnt_q == LastCnt) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs come only from registered state: no path from load/din.
  assign bus.ready = (state_q == StIdle);
  assign bus.busy  = (state_q == StShift);
  assign bus.data  = (state_q == StShift) & sr_q[WIDTH-1];
  assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_frame_feeder.sv
module tb_serial_frame_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_frame_feeder_if #(.WIDTH(5)) bus0 ();
  serial_frame_feeder_if #(.WIDTH(5)) bus1 ();

  serial_frame_feeder #(.WIDTH(5), .LSB_FIRST(1'b0)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  serial_frame_feeder #(.WIDTH(5), .LSB_FIRST(1'b1)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // Downstream 5-stage right-shift chain a -> e fed by the MSB-first feeder.
  logic a, b, c, d, e;
  always @(posedge clk) begin
    a <= bus0.data;
    b <= a;
    c <= b;
    d <= c;
    e <= d;
  end

  // Expected events: 0/1 = serial bit during busy, 2 = done pulse.
  int q0[$];
  int q1[$];
  logic [4:0] cq[$];  // expected {e,d,c,b,a} at each u_msb done pulse

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    nchecks++;
    if (act !== req) begin
      nerrors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic mon(input int id, input logic rdy, input logic dat, input logic bsy,
                     input logic dn, input logic [4:0] chain);
    int ev;
    int qs;
    chk($sformatf("dut%0d_ready_vs_busy", id), {7'b0, rdy}, {7'b0, ~bsy});
    if (!bsy) chk($sformatf("dut%0d_idle_data", id), {7'b0, dat}, 8'h00);
    if (bsy || dn) begin
      qs = (id == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL dut%0d_unexpected_output: busy=%0b done=%0b, required no activity at %0t",
                 id, bsy, dn, $time);
      end else begin
        if (id == 0) ev = q0.pop_front();
        else         ev = q1.pop_front();
        chk($sformatf("dut%0d_event_kind", id), {6'b0, bsy, dn},
            (ev == 2) ? 8'h01 : 8'h02);
        if (bsy && ev != 2) chk($sformatf("dut%0d_serial_bit", id), {7'b0, dat}, 8'(ev));
        if (dn && ev == 2 && id == 0 && cq.size() > 0)
          chk("chain_abcde_at_done", {3'b0, chain}, {3'b0, cq.pop_front()});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.ready, bus0.data, bus0.busy, bus0.done, {e, d, c, b, a});
    mon(1, bus1.ready, bus1.data, bus1.busy, bus1.done, 5'b0);
  end

  task automatic push_frame(input int id, input logic [4:0] bits_in_order);
    for (int i = 4; i >= 0; i--) begin
      if (id == 0) q0.push_back(int'(bits_in_order[i]));
      else         q1.push_back(int'(bits_in_order[i]));
    end
    if (id == 0) q0.push_back(2);
    else         q1.push_back(2);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.load = 1'b1;
    bus0.din  = 5'b11111;
    bus1.load = 1'b1;
    bus1.din  = 5'b11111;

    // Reset held across edges with load asserted: nothing starts.
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rst_ready0", {7'b0, bus0.ready}, 8'h01);
      chk("rst_busy0",  {7'b0, bus0.busy},  8'h00);
      chk("rst_data0",  {7'b0, bus0.data},  8'h00);
      chk("rst_done0",  {7'b0, bus0.done},  8'h00);
      chk("rst_busy1",  {7'b0, bus1.busy},  8'h00);
      chk("rst_done1",  {7'b0, bus1.done},  8'h00);
    end
    bus0.load = 1'b0;
    bus1.load = 1'b0;
    reset = 1'b0;
    tick(2);

    // Single frame 10110, MSB first: 1,0,1,1,0 then done; chain a..e = 0,1,1,0,1.
    bus0.din  = 5'b10110;
    bus0.load = 1'b1;
    push_frame(0, 5'b10110);
    cq.push_back(5'b10110);
    tick(1);
    bus0.load = 1'b0;
    bus0.din  = 5'b00000;
    tick(7);
    chk("ready_after_frame", {7'b0, bus0.ready}, 8'h01);

    // load during bit 2 is ignored.
    bus0.din  = 5'b10110;
    bus0.load = 1'b1;
    push_frame(0, 5'b10110);
    cq.push_back(5'b10110);
    tick(1);
    bus0.load = 1'b0;
    tick(2);
    bus0.din  = 5'b11111;
    bus0.load = 1'b1;
    tick(1);
    bus0.load = 1'b0;
    tick(5);
    chk("ready_after_ignored_load", {7'b0, bus0.ready}, 8'h01);
    chk("busy_after_ignored_load",  {7'b0, bus0.busy},  8'h00);

    // Reset during bit 3 aborts at once with no done.
    bus0.din  = 5'b11111;
    bus0.load = 1'b1;
    push_frame(0, 5'b11111);
    cq.push_back(5'b11111);
    tick(1);
    bus0.load = 1'b0;
    tick(3);
    reset = 1'b1;
    #1;
    chk("abort_data", {7'b0, bus0.data}, 8'h00);
    chk("abort_busy", {7'b0, bus0.busy}, 8'h00);
    chk("abort_done", {7'b0, bus0.done}, 8'h00);
    q0.delete();
    cq.delete();
    tick(1);
    reset = 1'b0;
    tick(2);
    bus0.din  = 5'b00001;
    bus0.load = 1'b1;
    push_frame(0, 5'b00001);
    cq.push_back(5'b00001);
    tick(1);
    bus0.load = 1'b0;
    tick(8);

    // LSB first, back-to-back with load held: 0,1,1,0,1, dead cycle, 1,1,0,0,0.
    bus1.din  = 5'b10110;
    bus1.load = 1'b1;
    push_frame(1, 5'b01101);
    push_frame(1, 5'b11000);
    tick(1);
    bus1.din = 5'b00011;
    tick(6);
    bus1.load = 1'b0;
    tick(8);

    chk("queue0_drained", 8'(q0.size()), 8'h00);
    chk("queue1_drained", 8'(q1.size()), 8'h00);
    chk("chainq_drained", 8'(cq.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
